// File: rtl/bcd_time_counter.sv
// BCD time-of-day counter (hh:mm:ss.hh) with per-field validated loads; optional 12-hour build via BCD_TIME_COUNTER_12H_EN.
// Latency: 1 cycle from load strobe or prescaler terminal count to time_out / tick_out / rollover / load_err.
// Backpressure: none; strobes are sampled every cycle, and a load in a tick cycle wins and discards that tick.
module bcd_time_counter #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [31:0] load_time,
  input  logic        load_hour,
  input  logic        load_minute,
  input  logic        load_second,
  input  logic        load_mil,
  output logic [31:0] time_out,
  output logic        tick_out,
  output logic        rollover,
  output logic        load_err,
  output logic        pm
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] PRESC_LAST = CW'(DIV - 1);

`ifdef BCD_TIME_COUNTER_12H_EN
  localparam logic [7:0] HOUR_RST = 8'h12;
`else
  localparam logic [7:0] HOUR_RST = 8'h00;
`endif

  logic [CW-1:0] presc;
  logic [7:0]    hour, minute, second, mil;
  logic          pm_q;

  // BCD increment of a two-digit byte; low digit 9 wraps to 0 and carries.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic digit_ok(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

  logic tick, any_load;
  logic mil_ok, sec_ok, min_ok, hour_ok, err;
  logic mil_wrap, sec_wrap, min_wrap, hour_carry;
  logic [7:0] mil_n, sec_n, min_n, hour_n;
  logic roll_n, pm_n;

  // Terminal count, field validation and the single-cycle carry chain.
  always_comb begin
    tick     = run && (presc == PRESC_LAST);
    any_load = load_hour | load_minute | load_second | load_mil;

    mil_ok = digit_ok(load_time[3:0])   && digit_ok(load_time[7:4]);
    sec_ok = digit_ok(load_time[11:8])  && (load_time[15:12] <= 4'd5);
    min_ok = digit_ok(load_time[19:16]) && (load_time[23:20] <= 4'd5);
`ifdef BCD_TIME_COUNTER_12H_EN
    hour_ok = ((load_time[31:28] == 4'd0) && (load_time[27:24] != 4'd0) && digit_ok(load_time[27:24]))
           || ((load_time[31:28] == 4'd1) && (load_time[27:24] <= 4'd2));
`else
    hour_ok = ((load_time[31:28] <= 4'd1) && digit_ok(load_time[27:24]))
           || ((load_time[31:28] == 4'd2) && (load_time[27:24] <= 4'd3));
`endif
    err = (load_mil && !mil_ok) || (load_second && !sec_ok)
       || (load_minute && !min_ok) || (load_hour && !hour_ok);

    mil_wrap   = (mil == 8'h99);
    sec_wrap   = (second == 8'h59);
    min_wrap   = (minute == 8'h59);
    hour_carry = mil_wrap && sec_wrap && min_wrap;

    mil_n = mil_wrap ? 8'h00 : bcd_inc(mil);
    sec_n = mil_wrap ? (sec_wrap ? 8'h00 : bcd_inc(second)) : second;
    min_n = (mil_wrap && sec_wrap) ? (min_wrap ? 8'h00 : bcd_inc(minute)) : minute;

    hour_n = hour;
    roll_n = 1'b0;
    pm_n   = pm_q;
    if (hour_carry) begin
`ifdef BCD_TIME_COUNTER_12H_EN
      // 12 is followed by 1; 11 -> 12 flips AM/PM and the PM->AM flip is midnight.
      hour_n = (hour == 8'h12) ? 8'h01 : bcd_inc(hour);
      if (hour == 8'h11) begin
        pm_n   = ~pm_q;
        roll_n = pm_q;
      end
`else
      hour_n = (hour == 8'h23) ? 8'h00 : bcd_inc(hour);
      roll_n = (hour == 8'h23);
`endif
    end
  end

  // Prescaler, time fields and pulse outputs; reset first, then load beats tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      hour     <= HOUR_RST;
      minute   <= 8'h00;
      second   <= 8'h00;
      mil      <= 8'h00;
      pm_q     <= 1'b0;
      tick_out <= 1'b0;
      rollover <= 1'b0;
      load_err <= 1'b0;
    end else begin
      if (load_mil)     presc <= '0;
      else if (run)     presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;

      tick_out <= tick && !any_load;
      rollover <= tick && !any_load && roll_n;
      load_err <= err;

      if (any_load) begin
        if (load_hour   && hour_ok) hour   <= load_time[31:24];
        if (load_minute && min_ok)  minute <= load_time[23:16];
        if (load_second && sec_ok)  second <= load_time[15:8];
        if (load_mil    && mil_ok)  mil    <= load_time[7:0];
      end else if (tick) begin
        hour   <= hour_n;
        minute <= min_n;
        second <= sec_n;
        mil    <= mil_n;
        pm_q   <= pm_n;
      end
    end
  end

  assign time_out = {hour, minute, second, mil};

`ifdef BCD_TIME_COUNTER_12H_EN
  assign pm = pm_q;
`else
  assign pm = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench for bcd_time_counter with DIV=10; covers the 12-hour build when BCD_TIME_COUNTER_12H_EN is defined.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: none; inputs are driven between edges.
module tb_bcd_time_counter;

  logic        clk = 1'b0;
  logic        rst, run;
  logic [31:0] load_time;
  logic        load_hour, load_minute, load_second, load_mil;
  logic [31:0] time_out;
  logic        tick_out, rollover, load_err, pm;

  int n_cmp = 0;
  int n_err = 0;

`ifdef BCD_TIME_COUNTER_12H_EN
  localparam logic [7:0] HR0 = 8'h12;
`else
  localparam logic [7:0] HR0 = 8'h00;
`endif

  bcd_time_counter #(.CLK_HZ(10), .TICK_HZ(1)) dut (
    .clk(clk), .rst(rst), .run(run), .load_time(load_time),
    .load_hour(load_hour), .load_minute(load_minute),
    .load_second(load_second), .load_mil(load_mil),
    .time_out(time_out), .tick_out(tick_out), .rollover(rollover),
    .load_err(load_err), .pm(pm)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic strobes(input logic h, input logic m, input logic s, input logic ml);
    load_hour = h; load_minute = m; load_second = s; load_mil = ml;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; load_time = 32'h0;
    strobes(0, 0, 0, 0);
    step(2);
    chk("rst_time", time_out, {HR0, 24'h000000});
    chk("rst_tick", {31'd0, tick_out}, 32'd0);
    chk("rst_roll", {31'd0, rollover}, 32'd0);
    chk("rst_err",  {31'd0, load_err}, 32'd0);
    chk("rst_pm",   {31'd0, pm}, 32'd0);

    // Free run for 30 cycles: ticks after edges 10, 20, 30.
    rst = 1'b0; run = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step(1);
      chk($sformatf("run_tick_%0d", i), {31'd0, tick_out}, {31'd0, (i % 10) == 0});
    end
    chk("run_time", time_out, {HR0, 24'h000003});

`ifdef BCD_TIME_COUNTER_12H_EN
    // 11:59:59.99 AM -> 12:00:00.00 PM, no rollover.
    load_time = 32'h11595999; strobes(1, 1, 1, 1);
    step(1);
    strobes(0, 0, 0, 0);
    chk("pm_load", time_out, 32'h11595999);
    step(10);
    chk("pm_time", time_out, 32'h12000000);
    chk("pm_pm",   {31'd0, pm}, 32'd1);
    chk("pm_roll", {31'd0, rollover}, 32'd0);
    // 11:59:59.99 PM -> 12:00:00.00 AM is midnight: rollover.
    strobes(1, 1, 1, 1);
    step(1);
    strobes(0, 0, 0, 0);
    chk("am_pm_kept", {31'd0, pm}, 32'd1);
    step(10);
    chk("am_time", time_out, 32'h12000000);
    chk("am_pm",   {31'd0, pm}, 32'd0);
    chk("am_roll", {31'd0, rollover}, 32'd1);
    step(1);
    chk("am_roll_end", {31'd0, rollover}, 32'd0);
`else
    // 23:59:59.99 -> 00:00:00.00 with one-cycle rollover.
    load_time = 32'h23595999; strobes(1, 1, 1, 1);
    step(1);
    strobes(0, 0, 0, 0);
    chk("roll_load", time_out, 32'h23595999);
    chk("roll_load_tick", {31'd0, tick_out}, 32'd0);
    step(9);
    chk("roll_pre", time_out, 32'h23595999);
    chk("roll_pre_r", {31'd0, rollover}, 32'd0);
    step(1);
    chk("roll_time", time_out, 32'h00000000);
    chk("roll_pulse", {31'd0, rollover}, 32'd1);
    chk("roll_tick", {31'd0, tick_out}, 32'd1);
    step(1);
    chk("roll_end", {31'd0, rollover}, 32'd0);
    chk("roll_tick_end", {31'd0, tick_out}, 32'd0);
`endif

    // Known time with run held off; prescaler cleared by load_mil.
    run = 1'b0;
    load_time = 32'h01020304; strobes(1, 1, 1, 1);
    step(1);
    strobes(0, 0, 0, 0);
    chk("set_time", time_out, 32'h01020304);

    // Illegal minutes rejected, legal seconds written in the same cycle.
    load_time = 32'h006A4200; strobes(0, 1, 1, 0);
    step(1);
    strobes(0, 0, 0, 0);
    chk("bad_min_time", time_out, 32'h01024204);
    chk("bad_min_err",  {31'd0, load_err}, 32'd1);
    step(1);
    chk("bad_min_err_end", {31'd0, load_err}, 32'd0);

    // Hour load in the terminal-count cycle discards the tick.
    run = 1'b1;
    step(9);
    chk("coll_pre", time_out, 32'h01024204);
    load_time = 32'h07000000; strobes(1, 0, 0, 0);
    step(1);
    strobes(0, 0, 0, 0);
    chk("coll_time", time_out, 32'h07024204);
    chk("coll_tick", {31'd0, tick_out}, 32'd0);
    chk("coll_err",  {31'd0, load_err}, 32'd0);
    step(10);
    chk("coll_next_time", time_out, 32'h07024205);
    chk("coll_next_tick", {31'd0, tick_out}, 32'd1);

    // Reset mid-prescale discards the partial count.
    load_time = 32'h01020304; strobes(1, 1, 1, 1);
    step(1);
    strobes(0, 0, 0, 0);
    step(5);
    chk("mid_time", time_out, 32'h01020304);
    rst = 1'b1;
    step(1);
    chk("mid_rst_time", time_out, {HR0, 24'h000000});
    chk("mid_rst_tick", {31'd0, tick_out}, 32'd0);
    chk("mid_rst_pm",   {31'd0, pm}, 32'd0);
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      chk($sformatf("post_rst_tick_%0d", i), {31'd0, tick_out}, {31'd0, i == 10});
    end
    chk("post_rst_time", time_out, {HR0, 24'h000001});

    // Illegal hour and hundredths both rejected.
    run = 1'b0;
    load_time = 32'h2400009A; strobes(1, 0, 0, 1);
    step(1);
    strobes(0, 0, 0, 0);
    chk("bad_hr_time", time_out, {HR0, 24'h000001});
    chk("bad_hr_err",  {31'd0, load_err}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
